// File: rtl/vga_box_mover_param.sv
// Parametrised VGA raster generator with one movable solid box over a solid background.
// Box moves once per frame: manual (clamp or wrap at edges) or autonomous bounce.
module vga_box_mover_param #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_NEG = 1'b1,
  parameter int unsigned CW       = 4,
  parameter int unsigned SIZE     = 50,
  parameter int unsigned STEP     = 3,
  parameter int unsigned X_INIT   = 300,
  parameter int unsigned Y_INIT   = 220,
  parameter logic [3*CW-1:0] BOX_RGB = {4'hA, 4'h2, 4'hD},
  parameter logic [3*CW-1:0] BG_RGB  = {4'hF, 4'hF, 4'hF}
) (
  input  logic          CLOCK_50,
  input  logic          RESET,
  input  logic [3:0]    KEY,
  input  logic          AUTO,
  input  logic          WRAP,
  output logic [CW-1:0] VGA_R,
  output logic [CW-1:0] VGA_G,
  output logic [CW-1:0] VGA_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          FRAME_TICK,
  output logic [10:0]   X_POS,
  output logic [10:0]   Y_POS
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] L_DIV_LAST = DW'(CLK_DIV - 1);

  localparam logic [11:0] L_H_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] L_V_LAST  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] L_H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] L_V_ACT   = 12'(V_ACTIVE);
  localparam logic [11:0] L_HS_BEG  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] L_HS_END  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] L_VS_BEG  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] L_VS_END  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] L_SIZE    = 12'(SIZE);
  localparam logic [10:0] L_XMAX    = 11'(H_ACTIVE - SIZE);
  localparam logic [10:0] L_YMAX    = 11'(V_ACTIVE - SIZE);
  localparam logic [10:0] L_X_INIT  = 11'(X_INIT);
  localparam logic [10:0] L_Y_INIT  = 11'(Y_INIT);
  localparam logic signed [11:0] L_STEP = 12'(STEP);

  // One axis of the per-frame move; returns {new_dir, new_pos}.
  function automatic logic [11:0] f_axis(
    input logic [10:0] pos,
    input logic        dec,
    input logic        inc,
    input logic        dir,
    input logic        wrap,
    input logic        aut,
    input logic [10:0] pmax
  );
    logic signed [11:0] p;
    logic signed [11:0] m;
    logic signed [11:0] s;
    logic signed [11:0] n;
    logic               nd;
    p  = $signed({1'b0, pos});
    m  = $signed({1'b0, pmax});
    s  = 12'sd0;
    nd = dir;
    if (aut)
      s = dir ? L_STEP : -L_STEP;
    else if (dec && !inc)
      s = -L_STEP;
    else if (inc && !dec)
      s = L_STEP;
    n = p + s;
    if (n > m) begin
      if (aut) begin
        n  = m;
        nd = 1'b0;
      end else if (wrap) begin
        n = n - m - 12'sd1;
      end else begin
        n = m;
      end
    end else if (n < 12'sd0) begin
      if (aut) begin
        n  = 12'sd0;
        nd = 1'b1;
      end else if (wrap) begin
        n = n + m + 12'sd1;
      end else begin
        n = 12'sd0;
      end
    end
    return {nd, n[10:0]};
  endfunction

  logic [DW-1:0]   r_div;
  logic [11:0]     r_h;
  logic [11:0]     r_v;
  logic [10:0]     r_x;
  logic [10:0]     r_y;
  logic            r_dir_x;
  logic            r_dir_y;

  logic            w_pe;
  logic            w_h_end;
  logic            w_v_end;
  logic            w_frame_end;
  logic            w_vis;
  logic            w_box;
  logic            w_hs_on;
  logic            w_vs_on;
  logic [3*CW-1:0] w_rgb;
  logic [11:0]     w_nx;
  logic [11:0]     w_ny;

  assign w_pe        = (r_div == L_DIV_LAST);
  assign w_h_end     = (r_h == L_H_LAST);
  assign w_v_end     = (r_v == L_V_LAST);
  assign w_frame_end = w_pe && w_h_end && w_v_end;

  assign w_vis   = (r_h < L_H_ACT) && (r_v < L_V_ACT);
  assign w_box   = (r_h >= {1'b0, r_x}) && (r_h < ({1'b0, r_x} + L_SIZE)) &&
                   (r_v >= {1'b0, r_y}) && (r_v < ({1'b0, r_y} + L_SIZE));
  assign w_hs_on = (r_h >= L_HS_BEG) && (r_h < L_HS_END);
  assign w_vs_on = (r_v >= L_VS_BEG) && (r_v < L_VS_END);
  assign w_rgb   = !w_vis ? '0 : (w_box ? BOX_RGB : BG_RGB);

  assign w_nx = f_axis(r_x, ~KEY[3], ~KEY[2], r_dir_x, WRAP, AUTO, L_XMAX);
  assign w_ny = f_axis(r_y, ~KEY[0], ~KEY[1], r_dir_y, WRAP, AUTO, L_YMAX);

  assign X_POS = r_x;
  assign Y_POS = r_y;

  // Pixel-enable divider and raster counters.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_pe ? '0 : r_div + DW'(1);
      if (w_pe) begin
        r_h <= w_h_end ? '0 : r_h + 12'd1;
        if (w_h_end)
          r_v <= w_v_end ? '0 : r_v + 12'd1;
      end
    end
  end

  // Pixel and sync registers load together so they stay aligned.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      VGA_R      <= '0;
      VGA_G      <= '0;
      VGA_B      <= '0;
      VGA_HS     <= SYNC_NEG;
      VGA_VS     <= SYNC_NEG;
      FRAME_TICK <= 1'b0;
    end else begin
      FRAME_TICK <= w_frame_end;
      if (w_pe) begin
        VGA_R  <= w_rgb[3*CW-1:2*CW];
        VGA_G  <= w_rgb[2*CW-1:CW];
        VGA_B  <= w_rgb[CW-1:0];
        VGA_HS <= w_hs_on ^ SYNC_NEG;
        VGA_VS <= w_vs_on ^ SYNC_NEG;
      end
    end
  end

  // Box position and bounce directions change only at frame end.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_x     <= L_X_INIT;
      r_y     <= L_Y_INIT;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (w_frame_end) begin
      r_x     <= w_nx[10:0];
      r_y     <= w_ny[10:0];
      r_dir_x <= w_nx[11];
      r_dir_y <= w_ny[11];
    end
  end

endmodule

// File: tb/tb_vga_box_mover_param.sv
// Bench for vga_box_mover_param on a reduced raster: an edge-count reference model
// checked every cycle, plus hand-computed pixel, sync and position expectations.
module tb_vga_box_mover_param;

  localparam int D   = 2;
  localparam int HA  = 20;
  localparam int HFP = 2;
  localparam int HSY = 3;
  localparam int HBP = 3;
  localparam int VA  = 15;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 2;
  localparam int SZ  = 5;
  localparam int ST  = 3;
  localparam int XI  = 2;
  localparam int YI  = 9;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FD  = HT * VT * D;
  localparam int XM  = HA - SZ;
  localparam int YM  = VA - SZ;
  localparam logic [11:0] BOX = 12'hA2D;
  localparam logic [11:0] BG  = 12'hFFF;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic [3:0]  KEY      = 4'b0111;
  logic        AUTO     = 1'b0;
  logic        WRAP     = 1'b0;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        FRAME_TICK;
  logic [10:0] X_POS;
  logic [10:0] Y_POS;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  vga_box_mover_param #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .SYNC_NEG(1'b1),
    .CW(4), .SIZE(SZ), .STEP(ST), .X_INIT(XI), .Y_INIT(YI),
    .BOX_RGB(BOX), .BG_RGB(BG)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY), .AUTO(AUTO), .WRAP(WRAP),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .FRAME_TICK(FRAME_TICK), .X_POS(X_POS), .Y_POS(Y_POS)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference move for one axis, from the movement rules in plain integer arithmetic.
  function automatic int step_axis(input int pos, input bit dec, input bit inc, input bit am,
                                   input bit wm, input int lim, input bit dir, output bit ndir);
    int t;
    ndir = dir;
    if (am) begin
      t = pos + (dir ? ST : -ST);
      if (t > lim) begin t = lim; ndir = 1'b0; end
      else if (t < 0) begin t = 0; ndir = 1'b1; end
    end else begin
      t = pos + ((dec == inc) ? 0 : (dec ? -ST : ST));
      if (wm) t = ((t % (lim + 1)) + (lim + 1)) % (lim + 1);
      else if (t < 0) t = 0;
      else if (t > lim) t = lim;
    end
    return t;
  endfunction

  // Model: everything derived from the number of clock edges since reset release.
  initial begin
    int e, mx, my, px, h, v;
    bit dx, dy, ndx, ndy, tick, vis, inb;
    logic [11:0] ergb;
    logic ehs, evs;
    logic [3:0] k;
    bit a, w;
    e = 0; mx = XI; my = YI; dx = 1'b1; dy = 1'b1;
    forever begin
      @(posedge CLOCK_50 or posedge RESET);
      tick = 1'b0;
      if (RESET) begin
        e = 0; mx = XI; my = YI; dx = 1'b1; dy = 1'b1;
      end else begin
        k = KEY; a = AUTO; w = WRAP;
        e++;
        tick = (e % FD) == 0;
      end
      if (e < D) begin
        ergb = 12'h000; ehs = 1'b1; evs = 1'b1;
      end else begin
        px   = e / D - 1;
        h    = px % HT;
        v    = (px / HT) % VT;
        vis  = (h < HA) && (v < VA);
        inb  = (h >= mx) && (h < mx + SZ) && (v >= my) && (v < my + SZ);
        ergb = !vis ? 12'h000 : (inb ? BOX : BG);
        ehs  = !((h >= HA + HFP) && (h < HA + HFP + HSY));
        evs  = !((v >= VA + VFP) && (v < VA + VFP + VSY));
      end
      if (tick) begin
        mx = step_axis(mx, !k[3], !k[2], a, w, XM, dx, ndx);
        my = step_axis(my, !k[0], !k[1], a, w, YM, dy, ndy);
        dx = ndx; dy = ndy;
      end
      #1;
      check("model_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(ergb));
      check("model_hs", 32'(VGA_HS), 32'(ehs));
      check("model_vs", 32'(VGA_VS), 32'(evs));
      check("model_tick", 32'(FRAME_TICK), 32'(tick));
      check("model_x", 32'(X_POS), 32'(mx));
      check("model_y", 32'(Y_POS), 32'(my));
    end
  end

  task automatic go_to(input int n);
    repeat (n - cur) @(posedge CLOCK_50);
    #1;
    cur = n;
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge CLOCK_50);
      seen = FRAME_TICK;
    end
    check("frame_tick_seen", 32'(seen), 32'd1);
  endtask

  task automatic frame(input logic [3:0] k, input logic a, input logic w,
                       input int ex, input int ey, input bit toggle);
    KEY = k; AUTO = a; WRAP = w;
    if (toggle) begin
      repeat (300) @(negedge CLOCK_50);
      KEY = 4'b0000; AUTO = 1'b1;
      repeat (300) @(negedge CLOCK_50);
      KEY = k; AUTO = a;
    end
    wait_tick();
    check("frame_x", 32'(X_POS), 32'(ex));
    check("frame_y", 32'(Y_POS), 32'(ey));
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b0;
    cur = 0;
    // Hand-computed raster points of the first frame, box at (2,9).
    go_to(42);   check("blank_h20", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
                 check("hs_h20", 32'(VGA_HS), 32'd1);
    go_to(44);   check("hs_h21", 32'(VGA_HS), 32'd1);
    go_to(46);   check("hs_h22", 32'(VGA_HS), 32'd0);
    go_to(50);   check("hs_h24", 32'(VGA_HS), 32'd0);
    go_to(52);   check("hs_h25", 32'(VGA_HS), 32'd1);
    go_to(508);  check("px_1_9", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFF);
    go_to(510);  check("px_2_9", 32'({VGA_R, VGA_G, VGA_B}), 32'hA2D);
    go_to(520);  check("px_7_9", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFF);
    go_to(742);  check("px_6_13", 32'({VGA_R, VGA_G, VGA_B}), 32'hA2D);
    go_to(798);  check("px_6_14", 32'({VGA_R, VGA_G, VGA_B}), 32'hFFF);
    go_to(842);  check("vs_v15", 32'(VGA_VS), 32'd1);
                 check("blank_v15", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
    go_to(898);  check("vs_v16", 32'(VGA_VS), 32'd0);
    go_to(1010); check("vs_v18", 32'(VGA_VS), 32'd1);
    go_to(1119); check("tick_before", 32'(FRAME_TICK), 32'd0);
                 check("x_before", 32'(X_POS), 32'd2);
    go_to(1120); check("tick_at_end", 32'(FRAME_TICK), 32'd1);
                 check("x_clamp_left", 32'(X_POS), 32'd0);
                 check("y_hold", 32'(Y_POS), 32'd9);
    @(negedge CLOCK_50);
    // Directed frames: clamp, wrap, multi-key, then bounce.
    frame(4'b0111, 1'b0, 1'b0,  0,  9, 1'b0);
    frame(4'b1101, 1'b0, 1'b0,  0, 10, 1'b0);
    frame(4'b0111, 1'b0, 1'b1, 13, 10, 1'b0);
    frame(4'b1011, 1'b0, 1'b1,  0, 10, 1'b0);
    frame(4'b0010, 1'b0, 1'b1,  0,  7, 1'b1);
    frame(4'b1110, 1'b0, 1'b1,  0,  4, 1'b0);
    frame(4'b1110, 1'b0, 1'b1,  0,  1, 1'b0);
    frame(4'b1110, 1'b0, 1'b1,  0,  9, 1'b0);
    frame(4'b0000, 1'b1, 1'b1,  3, 10, 1'b0);
    frame(4'b0000, 1'b1, 1'b0,  6,  7, 1'b0);
    frame(4'b0000, 1'b1, 1'b0,  9,  4, 1'b0);
    frame(4'b0000, 1'b1, 1'b0, 12,  1, 1'b0);
    frame(4'b0000, 1'b1, 1'b0, 15,  0, 1'b0);
    frame(4'b0000, 1'b1, 1'b0, 15,  3, 1'b0);
    frame(4'b0000, 1'b1, 1'b0, 12,  6, 1'b0);
    frame(4'b1111, 1'b0, 1'b0, 12,  6, 1'b0);
    // Random inputs with mid-frame changes; the model checks every cycle.
    for (int f = 0; f < 14; f++) begin
      KEY  = 4'($urandom);
      AUTO = ($urandom_range(0, 2) == 0);
      WRAP = 1'($urandom);
      repeat ($urandom_range(50, 900)) @(negedge CLOCK_50);
      KEY  = 4'($urandom);
      AUTO = ($urandom_range(0, 2) == 0);
      WRAP = 1'($urandom);
      wait_tick();
    end
    // Drive the box away from its reset position, then reset mid-line.
    frame(4'b1011, 1'b0, 1'b0, 32'(X_POS) + 3 > XM ? XM : 32'(X_POS) + 3, 32'(Y_POS), 1'b0);
    repeat (37) @(negedge CLOCK_50);
    #3 RESET = 1'b1;
    #1;
    check("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'h000);
    check("rst_hs", 32'(VGA_HS), 32'd1);
    check("rst_vs", 32'(VGA_VS), 32'd1);
    check("rst_tick", 32'(FRAME_TICK), 32'd0);
    check("rst_x", 32'(X_POS), 32'd2);
    check("rst_y", 32'(Y_POS), 32'd9);
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
